// File: rtl/gf180mcu_fd_sc_mcu7t5v0__arb_pkg.sv
// gf180mcu_fd_sc_mcu7t5v0__arb_pkg: shared FSM encoding and rotate-priority pick for the 4-way arbiter
package gf180mcu_fd_sc_mcu7t5v0__arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;
  // Scan from the highest offset down so the index closest to ptr is the one left standing.
  function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] j;
    rr_pick = '0;
    for (int i = 3; i >= 0; i--) begin
      j = ptr + 2'(i);
      if (req[j]) rr_pick = 4'b0001 << j;
    end
  endfunction
endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb4_pick.sv
// gf180mcu_fd_sc_mcu7t5v0__rrarb4_pick: combinational rotate-priority picker, one-hot plus index
module gf180mcu_fd_sc_mcu7t5v0__rrarb4_pick
  import gf180mcu_fd_sc_mcu7t5v0__arb_pkg::*;
(
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_oh,
  output logic [1:0] o_idx
);
  assign o_oh  = rr_pick(i_req, i_ptr);
  assign o_idx = {o_oh[3] | o_oh[2], o_oh[3] | o_oh[1]};
endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb4_1.sv
// gf180mcu_fd_sc_mcu7t5v0__rrarb4_1: 4-requester round-robin arbiter with bounded tenure and break-before-make gap
module gf180mcu_fd_sc_mcu7t5v0__rrarb4_1
  import gf180mcu_fd_sc_mcu7t5v0__arb_pkg::*;
#(
  parameter int MAXHOLD = 8,
  parameter int CW      = 4
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic       ANY,
  output logic       BUSY,
  inout  wire        VDD,
  inout  wire        VSS
);
  localparam logic [CW-1:0] LAST = CW'(MAXHOLD == 0 ? 0 : MAXHOLD - 1);
  logic [1:0] r_sync;
  logic w_rst_n, w_unused;
  state_t r_state, w_state;
  logic [3:0] r_gnt, w_gnt, w_poh;
  logic [1:0] r_ptr, w_ptr, r_idx, w_idx, w_pidx;
  logic [CW-1:0] r_cnt, w_cnt;
  logic r_busy, w_own, w_last, w_other;
  assign w_unused = VDD ^ VSS;
  // Assert immediately, release two clocks after RN rises.
  always_ff @(posedge CLK or negedge RN)
    if (!RN) r_sync <= 2'b00;
    else r_sync <= {r_sync[0], 1'b1};
  assign w_rst_n = r_sync[1];
  assign ANY  = |REQ;
  assign GNT  = r_gnt;
  assign BUSY = r_busy;
  gf180mcu_fd_sc_mcu7t5v0__rrarb4_pick u_pick (
    .i_req(REQ),
    .i_ptr(r_ptr),
    .o_oh (w_poh),
    .o_idx(w_pidx)
  );
  assign w_own   = REQ[r_idx];
  assign w_last  = (MAXHOLD != 0) && (r_cnt == LAST);
  assign w_other = |(REQ & ~r_gnt);
  // GAP outputs zero for its cycle but arbitrates exactly like IDLE.
  always_comb begin
    w_state = r_state;
    w_gnt   = r_gnt;
    w_ptr   = r_ptr;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    if (r_state == ST_GRANT) begin
      if (!w_own || (w_last && w_other)) begin
        w_state = ST_GAP;
        w_gnt   = '0;
        w_ptr   = r_idx + 2'd1;
        w_cnt   = '0;
      end else begin
        w_cnt = w_last ? '0 : (&r_cnt ? r_cnt : r_cnt + 1'b1);
      end
    end else begin
      w_state = ANY ? ST_GRANT : ST_IDLE;
      w_gnt   = w_poh;
      w_idx   = w_pidx;
      w_cnt   = '0;
    end
  end
  always_ff @(posedge CLK or negedge w_rst_n)
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_gnt   <= w_gnt;
      r_busy  <= |w_gnt;
      r_ptr   <= w_ptr;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
    end
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rrarb4_1.sv
// tb_gf180mcu_fd_sc_mcu7t5v0__rrarb4_1: checks MAXHOLD=8 and MAXHOLD=0 arbiters against a tenure-level model
module tb_gf180mcu_fd_sc_mcu7t5v0__rrarb4_1;
  logic clk = 1'b0;
  logic rn = 1'b0;
  logic [3:0] req = 4'b0000;
  wire vdd = 1'b1;
  wire vss = 1'b0;
  logic [3:0] g8, g0;
  logic b8, b0, a8, a0;
  int checks = 0;
  int errors = 0;
  int own[2], ten[2], ptr[2];
  int mh[2] = '{8, 0};
  int sc = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__rrarb4_1 #(.MAXHOLD(8), .CW(4)) dut (
    .CLK(clk), .RN(rn), .REQ(req), .GNT(g8), .ANY(a8), .BUSY(b8), .VDD(vdd), .VSS(vss)
  );
  gf180mcu_fd_sc_mcu7t5v0__rrarb4_1 #(.MAXHOLD(0), .CW(4)) dut0 (
    .CLK(clk), .RN(rn), .REQ(req), .GNT(g0), .ANY(a0), .BUSY(b0), .VDD(vdd), .VSS(vss)
  );

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      own[m] = -1;
      ten[m] = 0;
      ptr[m] = 0;
    end
    sc = 0;
  endfunction

  // Owner/tenure view: a free resource goes to the first requester from ptr; an owner leaves
  // when it stops asking, or when its tenure is used up while someone else waits.
  function automatic void model_step(int m, logic [3:0] r);
    int o;
    bit last, other;
    if (own[m] < 0) begin
      for (int i = 0; i < 4; i++) begin
        if (own[m] < 0 && r[(ptr[m] + i) % 4]) begin
          own[m] = (ptr[m] + i) % 4;
          ten[m] = 1;
        end
      end
    end else begin
      o = own[m];
      last = (mh[m] != 0) && (ten[m] == mh[m]);
      other = (r & ~(4'b0001 << o)) != 4'b0000;
      if (!r[o] || (last && other)) begin
        ptr[m] = (o + 1) % 4;
        own[m] = -1;
      end else ten[m] = last ? 1 : ten[m] + 1;
    end
  endfunction

  function automatic logic [3:0] ex(int m);
    return own[m] < 0 ? 4'b0000 : 4'(1 << own[m]);
  endfunction

  // Drive REQ on the falling edge, predict the next rising edge, then wait to the next falling edge.
  task automatic cyc(input logic [3:0] r);
    req = r;
    if (rn) begin
      if (sc >= 2) for (int m = 0; m < 2; m++) model_step(m, r);
      if (sc < 2) sc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    req = 4'b1111;
    repeat (3) @(negedge clk);
    checks++;
    if (g8 !== 4'b0000 || b8 !== 1'b0 || g0 !== 4'b0000 || b0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt gnt8=%b busy8=%b gnt0=%b busy0=%b want 0000/0", g8, b8, g0, b0);
    end
    checks++;
    if (a8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_any any=%b want 1", a8);
    end
    req = 4'b0000;
    rn = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0000);
      checks++;
      if (g8 !== 4'b0000 || a8 !== 1'b0 || b8 !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset gnt=%b any=%b busy=%b want 0000/0/0", g8, a8, b8);
      end
    end
  endtask

  task automatic test_single();
    cyc(4'b0100);
    checks++;
    if (g8 !== 4'b0100 || b8 !== 1'b1 || g0 !== 4'b0100) begin
      errors++;
      $display("FAIL single_latency gnt8=%b busy8=%b gnt0=%b want 0100/1", g8, b8, g0);
    end
    repeat (3) cyc(4'b0100);
    cyc(4'b0000);
    checks++;
    if (g8 !== 4'b0000 || b8 !== 1'b0) begin
      errors++;
      $display("FAIL single_release gnt=%b busy=%b want 0000/0", g8, b8);
    end
    cyc(4'b1001);
    checks++;
    if (g8 !== 4'b1000 || g0 !== 4'b1000 || g8 !== ex(0)) begin
      errors++;
      $display("FAIL single_next gnt8=%b gnt0=%b want 1000", g8, g0);
    end
    repeat (2) cyc(4'b0000);
  endtask

  task automatic test_fairness();
    int run;
    logic [3:0] prev;
    run = 0;
    prev = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      cyc(4'b1111);
      if (i == 0) begin
        checks++;
        if (g8 !== 4'b0001) begin
          errors++;
          $display("FAIL fair_first gnt=%b want 0001", g8);
        end
      end
      checks++;
      if (g8 !== ex(0) || b8 !== |ex(0) || g0 !== ex(1) || b0 !== |ex(1)) begin
        errors++;
        $display("FAIL fair_model cyc=%0d gnt8=%b busy8=%b want %b gnt0=%b busy0=%b want %b", i, g8, b8, ex(0), g0, b0, ex(1));
      end
      if (g8 != 4'b0000 && g8 == prev) run++;
      else if (g8 != 4'b0000) run = 1;
      if (g8 == 4'b0000 && prev != 4'b0000) begin
        checks++;
        if (run !== 8) begin
          errors++;
          $display("FAIL fair_tenure run=%0d want 8", run);
        end
      end
      prev = g8;
    end
    repeat (2) cyc(4'b0000);
  endtask

  task automatic test_sole();
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0010);
      checks++;
      if (g8 !== 4'b0010 || b8 !== 1'b1 || g8 !== ex(0)) begin
        errors++;
        $display("FAIL sole_hold cyc=%0d gnt=%b busy=%b want 0010/1", i, g8, b8);
      end
    end
    repeat (2) cyc(4'b0000);
  endtask

  task automatic test_unlimited();
    for (int i = 0; i < 15; i++) begin
      cyc(4'b0011);
      checks++;
      if (g0 !== 4'b0001 || g8 !== ex(0)) begin
        errors++;
        $display("FAIL unlim_hold cyc=%0d gnt0=%b want 0001 gnt8=%b want %b", i, g0, g8, ex(0));
      end
    end
    cyc(4'b0010);
    checks++;
    if (g0 !== 4'b0000 || b0 !== 1'b0) begin
      errors++;
      $display("FAIL unlim_gap gnt0=%b busy0=%b want 0000/0", g0, b0);
    end
    cyc(4'b0010);
    checks++;
    if (g0 !== 4'b0010 || g8 !== ex(0)) begin
      errors++;
      $display("FAIL unlim_next gnt0=%b want 0010 gnt8=%b want %b", g0, g8, ex(0));
    end
    repeat (2) cyc(4'b0000);
  endtask

  task automatic test_mid_reset();
    repeat (2) cyc(4'b0100);
    checks++;
    if (g8 !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_pre gnt=%b want 0100", g8);
    end
    req = 4'b1111;
    rn = 1'b0;
    #2;
    checks++;
    if (g8 !== 4'b0000 || b8 !== 1'b0 || g0 !== 4'b0000 || a8 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async gnt8=%b busy8=%b gnt0=%b any=%b want 0000/0/0000/1", g8, b8, g0, a8);
    end
    #2;
    rn = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    sc = 1;
    cyc(4'b1111);
    checks++;
    if (g8 !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_sync gnt=%b want 0000", g8);
    end
    cyc(4'b1111);
    checks++;
    if (g8 !== 4'b0001 || g0 !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_first gnt8=%b gnt0=%b want 0001", g8, g0);
    end
    repeat (2) cyc(4'b0000);
  endtask

  task automatic test_random();
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      cyc(r);
      checks++;
      if (g8 !== ex(0) || b8 !== |ex(0) || g0 !== ex(1) || b0 !== |ex(1) || a8 !== |r) begin
        errors++;
        $display("FAIL rand_model cyc=%0d req=%b gnt8=%b want %b gnt0=%b want %b any=%b", i, r, g8, ex(0), g0, ex(1), a8);
      end
      checks++;
      if ($countones(g8) > 1 || $countones(g0) > 1) begin
        errors++;
        $display("FAIL rand_onehot gnt8=%b gnt0=%b want at most one bit", g8, g0);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_sole();
    test_unlimited();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
